mfc_capture_sequencer: RTL and testbench
========================================

Name: mfc_capture_sequencer

Overview:
- Clocked front/back-end for the gate-level magnitude/flag comparator (MFC, outputs EQ/AE/GT/d).
- Accepts operand pairs over a valid/ready handshake and drives them onto the comparator's A/B inputs, which it holds stable.
- Waits a fixed settle window sized to the comparator's worst-case gate propagation, then registers EQ/AE/GT/d and offers them downstream over a second valid/ready handshake.
- Also keeps a transaction count and a sticky consistency-error flag.

Parameters:
- WIDTH, 16, operand width; must match the comparator instance.
- SETTLE_CYCLES, 8, clock edges from operand launch to result capture; legal range ≥1.
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair available.
- in_ready  out  1  sequencer can accept a pair this cycle.
- in_a  in  WIDTH  operand A, two's complement.
- in_b  in  WIDTH  operand B, two's complement.
- cmp_a  out  WIDTH  registered operand A driven to the comparator.
- cmp_b  out  WIDTH  registered operand B driven to the comparator.
- cmp_eq  in  1  comparator EQ.
- cmp_ae  in  1  comparator AE (|A|==|B|).
- cmp_gt  in  1  comparator GT (signed A>B).
- cmp_d  in  4  comparator d (index of the most-significant differing bit).
- out_valid  out  1  result registers hold a new result.
- out_ready  in  1  downstream consumes the result.
- res_eq  out  1  captured EQ.
- res_ae  out  1  captured AE.
- res_gt  out  1  captured GT.
- res_d  out  4  captured d.
- txn_count  out  CNT_W  number of results captured since reset; wraps modulo 2^CNT_W.
- err  out  1  sticky consistency error.

Behaviour:
- Reset (sync, rst=1 at an edge) applies regardless of state, including mid-SETTLE and mid-HOLD:
  - state=IDLE.
  - out_valid, res_*, cmp_a, cmp_b, txn_count and err all clear to 0.
  - The settle counter clears.
  - An in-flight pair is dropped with no result.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SETTLE: in_ready=0, out_valid=0.
  - HOLD: out_valid=1, in_ready=out_ready.
- Accept: at an edge with in_valid&&in_ready:
  - cmp_a<=in_a, cmp_b<=in_b.
  - settle counter<=SETTLE_CYCLES-1.
  - state<=SETTLE.
- SETTLE: the counter decrements each edge. At the edge where the counter==0:
  - res_eq/ae/gt/d <= cmp_eq/ae/gt/d.
  - txn_count += 1.
  - state<=HOLD.
- Latency: a pair accepted at edge T gets its result captured at edge T+SETTLE_CYCLES. out_valid is high from that edge onward.
- HOLD: the res_* registers and cmp_a/cmp_b stay stable until out_ready=1. On the edge with out_ready:
  - If in_valid is also high: accept the new pair (launch as above), state<=SETTLE, out_valid<=0. This is back-to-back with no idle bubble.
  - Otherwise: state<=IDLE, out_valid<=0.
- cmp_a/cmp_b change only on an accept; they hold the last operands in IDLE and HOLD.
- in_valid in SETTLE is ignored; the upstream source must hold in_a/in_b until accepted.
- Error check, evaluated on the captured values at the capture edge. err<=1 (sticky until rst) if any of:
  - eq&&gt
  - eq&&!ae
  - eq&&d!=0
- txn_count wraps from 2^CNT_W-1 to 0 with no flag.
- SETTLE_CYCLES=1: capture occurs at the edge right after accept; the counter loads 0.

Decomposition:
- Package mfc_pkg holds:
  - state enum {IDLE, SETTLE, HOLD}
  - MFC_WIDTH=16, MFC_D_W=4
  - result struct {eq, ae, gt, d}
- One sub-module: mfc_settle_timer.
  - Inputs: load, clk, rst.
  - Output: done pulse.
  - Internal counter width $clog2(SETTLE_CYCLES+1).
- FSM, handshake, capture and error logic stay in the top.

Test Plan:
- Bench comparator model: a behavioural MFC with output delay < SETTLE_CYCLES periods.
- Scenario 1: rst for 2 cycles, then in_a=16'h9796, in_b=16'hE86A accepted at edge T → at edge T+8 out_valid=1, res_eq=0, res_ae=0, res_gt=0, res_d=14, txn_count=1, err=0.
- Scenario 2: in_a=in_b=16'hFFFF → res_eq=1, res_ae=1, res_gt=0, res_d=0.
- Scenario 3: in_a=16'h0005, in_b=16'hFFFB → res_eq=0, res_ae=1, res_gt=1, res_d=15.
- Scenario 4: back-to-back and back-pressure.
  - Hold out_ready=0 for 5 cycles in HOLD → results, cmp_a and cmp_b stable, in_ready=0.
  - Then out_ready=1 together with in_valid=1 → new pair launched that edge; next result arrives 8 edges later.
- Scenario 5: reset mid-operation.
  - Assert rst at the 3rd SETTLE cycle → next edge: out_valid=0, state IDLE, txn_count=0, cmp_a=0; no result ever appears for the dropped pair.
- Scenario 6: error flag.
  - Force the model to return eq=1, gt=1 → err=1 after capture and stays 1 across later clean pairs until rst.
  - Separately, run 2^16 pairs with CNT_W=16 → txn_count wraps to 0.

Source files
------------

// File: rtl/mfc_capture_sequencer_pkg.sv
// Shared types and constants for the MFC capture sequencer and its settle timer.
package mfc_pkg;

    localparam int MFC_WIDTH = 16;
    localparam int MFC_D_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    typedef struct packed {
        logic               eq;
        logic               ae;
        logic               gt;
        logic [MFC_D_W-1:0] d;
    } mfc_result_t;

    // Equal operands must also be magnitude-equal, not greater, and have no differing bit.
    function automatic logic mfc_inconsistent(input mfc_result_t r);
        return (r.eq && r.gt) || (r.eq && !r.ae) || (r.eq && (r.d != '0));
    endfunction

endpackage

// File: rtl/mfc_settle_timer.sv
// Counts the comparator settle window after an operand launch and pulses done on the capture edge.
module mfc_settle_timer #(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          busy;

    assign done = busy && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            cnt  <= CW'(SETTLE_CYCLES - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mfc_capture_sequencer.sv
// Drives operand pairs onto the MFC comparator, waits out its settle window,
// then captures EQ/AE/GT/d and offers them downstream.
module mfc_capture_sequencer
    import mfc_pkg::*;
#(
    parameter int WIDTH         = MFC_WIDTH,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   cmp_a,
    output logic [WIDTH-1:0]   cmp_b,
    input  logic               cmp_eq,
    input  logic               cmp_ae,
    input  logic               cmp_gt,
    input  logic [MFC_D_W-1:0] cmp_d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               res_eq,
    output logic               res_ae,
    output logic               res_gt,
    output logic [MFC_D_W-1:0] res_d,
    output logic [CNT_W-1:0]   txn_count,
    output logic               err
);

    state_t      state;
    mfc_result_t res;
    mfc_result_t cap;
    logic        accept;
    logic        done;

    // HOLD accepts only as the held result drains, giving back-to-back launches.
    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign cap      = '{eq: cmp_eq, ae: cmp_ae, gt: cmp_gt, d: cmp_d};

    assign res_eq = res.eq;
    assign res_ae = res.ae;
    assign res_gt = res.gt;
    assign res_d  = res.d;

    mfc_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk (clk),
        .rst (rst),
        .load(accept),
        .done(done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            cmp_a     <= '0;
            cmp_b     <= '0;
            txn_count <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                cmp_a <= in_a;
                cmp_b <= in_b;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (done) begin
                        res       <= cap;
                        txn_count <= txn_count + CNT_W'(1);
                        err       <= err | mfc_inconsistent(cap);
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfc_capture_sequencer.sv
// Directed bench for mfc_capture_sequencer with a delayed behavioural comparator and a deadline-based reference model.
module tb_mfc_capture_sequencer;
    import mfc_pkg::*;

    localparam int S = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        force_err = 1'b0;
    logic        chk_en = 1'b0;

    logic        in_ready, out_valid, res_eq, res_ae, res_gt, err;
    logic [15:0] cmp_a, cmp_b, txn_count;
    logic [3:0]  res_d;
    logic        cmp_eq, cmp_ae, cmp_gt;
    logic [3:0]  cmp_d;

    logic        rst2 = 1'b1;
    logic        in_ready2, out_valid2, res_eq2, res_ae2, res_gt2, err2;
    logic [15:0] cmp_a2, cmp_b2;
    logic [3:0]  res_d2, txn_count2;
    mfc_result_t ref2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic mfc_result_t ref_mfc(input logic [15:0] a, input logic [15:0] b, input logic frc);
        mfc_result_t r;
        logic signed [16:0] sa, sb;
        logic [15:0] x;
        sa = {a[15], a};
        sb = {b[15], b};
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
        x = a ^ b;
        r.eq = (a == b);
        r.ae = (sa == sb);
        r.gt = ($signed(a) > $signed(b));
        r.d  = '0;
        for (int i = 0; i < 16; i++) if (x[i]) r.d = 4'(i);
        if (frc) begin
            r.eq = 1'b1;
            r.gt = 1'b1;
        end
        return r;
    endfunction

    // Comparator stand-in: result appears three clocks after cmp_a/cmp_b change.
    mfc_result_t pipe [3];
    always @(posedge clk) begin
        pipe[0] <= ref_mfc(cmp_a, cmp_b, force_err);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign cmp_eq = pipe[2].eq;
    assign cmp_ae = pipe[2].ae;
    assign cmp_gt = pipe[2].gt;
    assign cmp_d  = pipe[2].d;

    mfc_capture_sequencer #(
        .WIDTH(16),
        .SETTLE_CYCLES(S),
        .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_eq(cmp_eq), .cmp_ae(cmp_ae), .cmp_gt(cmp_gt), .cmp_d(cmp_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_eq(res_eq), .res_ae(res_ae), .res_gt(res_gt), .res_d(res_d),
        .txn_count(txn_count), .err(err)
    );

    // Second instance: minimum settle window and a narrow counter so wrap is reachable.
    always_comb ref2 = ref_mfc(cmp_a2, cmp_b2, 1'b0);

    mfc_capture_sequencer #(
        .WIDTH(16),
        .SETTLE_CYCLES(1),
        .CNT_W(4)
    ) dut2 (
        .clk(clk), .rst(rst2), .in_valid(1'b1), .in_ready(in_ready2),
        .in_a(16'h0005), .in_b(16'h0003), .cmp_a(cmp_a2), .cmp_b(cmp_b2),
        .cmp_eq(ref2.eq), .cmp_ae(ref2.ae), .cmp_gt(ref2.gt), .cmp_d(ref2.d),
        .out_valid(out_valid2), .out_ready(1'b1),
        .res_eq(res_eq2), .res_ae(res_ae2), .res_gt(res_gt2), .res_d(res_d2),
        .txn_count(txn_count2), .err(err2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a launched pair is due a fixed number of edges later.
    int          edge_no = 0;
    int          m_due = 0;
    logic        m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0;
    logic        m_launch, m_cap;
    logic [15:0] m_a = '0, m_b = '0, m_cnt = '0;
    mfc_result_t m_res = '0;

    always @(posedge clk) begin
        edge_no++;
        if (rst) begin
            m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0;
            m_a = '0; m_b = '0; m_cnt = '0; m_res = '0;
        end else begin
            m_cap    = m_busy && (edge_no == m_due);
            m_launch = in_valid && !m_busy && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_cap) begin
                m_res   = ref_mfc(m_a, m_b, force_err);
                m_cnt   = m_cnt + 16'd1;
                m_err   = m_err | (m_res.eq && (m_res.gt || !m_res.ae || m_res.d != 4'd0));
                m_valid = 1'b1;
                m_busy  = 1'b0;
            end
            if (m_launch) begin
                m_a = in_a; m_b = in_b;
                m_due  = edge_no + S;
                m_busy = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("in_ready", 32'(in_ready), 32'(!m_busy && (!m_valid || out_ready)));
            chk("cmp_a", 32'(cmp_a), 32'(m_a));
            chk("cmp_b", 32'(cmp_b), 32'(m_b));
            chk("txn_count", 32'(txn_count), 32'(m_cnt));
            chk("err", 32'(err), 32'(m_err));
            if (m_valid) begin
                chk("res", 32'({res_eq, res_ae, res_gt, res_d}), 32'(m_res));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain;
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset txn_count", 32'(txn_count), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // Scenario 1: first result exactly SETTLE_CYCLES edges after accept
        launch(16'h9796, 16'hE86A);
        step(S - 1);
        chk("s1 early out_valid", 32'(out_valid), 32'd0);
        step(1);
        chk("s1 out_valid", 32'(out_valid), 32'd1);
        chk("s1 res", 32'({res_eq, res_ae, res_gt, res_d}), 32'({3'b000, 4'd14}));
        chk("s1 txn_count", 32'(txn_count), 32'd1);
        chk("s1 err", 32'(err), 32'd0);
        drain();

        // Scenario 2
        launch(16'hFFFF, 16'hFFFF);
        step(S);
        chk("s2 res", 32'({res_eq, res_ae, res_gt, res_d}), 32'({3'b110, 4'd0}));
        drain();

        // Scenario 3, then back-pressure in HOLD
        launch(16'h0005, 16'hFFFB);
        step(S);
        chk("s3 res", 32'({res_eq, res_ae, res_gt, res_d}), 32'({3'b011, 4'd15}));
        step(5);
        chk("s4 hold out_valid", 32'(out_valid), 32'd1);
        chk("s4 hold res", 32'({res_eq, res_ae, res_gt, res_d}), 32'({3'b011, 4'd15}));
        chk("s4 hold cmp_a", 32'(cmp_a), 32'h0005);
        chk("s4 hold cmp_b", 32'(cmp_b), 32'hFFFB);
        chk("s4 hold in_ready", 32'(in_ready), 32'd0);

        // Scenario 4: drain and launch on the same edge
        out_ready = 1'b1; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h1230;
        #1;
        chk("s4 b2b in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("s4 b2b out_valid", 32'(out_valid), 32'd0);
        chk("s4 b2b cmp_a", 32'(cmp_a), 32'h1234);
        step(S - 1);
        chk("s4 b2b early", 32'(out_valid), 32'd0);
        step(1);
        chk("s4 b2b out_valid", 32'(out_valid), 32'd1);
        chk("s4 b2b res", 32'({res_eq, res_ae, res_gt, res_d}), 32'({3'b001, 4'd2}));
        chk("s4 b2b txn_count", 32'(txn_count), 32'd4);
        drain();

        // Scenario 5: reset in the third SETTLE cycle drops the pair
        launch(16'h00AA, 16'h0055);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("s5 out_valid", 32'(out_valid), 32'd0);
        chk("s5 txn_count", 32'(txn_count), 32'd0);
        chk("s5 cmp_a", 32'(cmp_a), 32'd0);
        chk("s5 in_ready", 32'(in_ready), 32'd1);
        step(12);
        chk("s5 no late result", 32'(out_valid), 32'd0);

        // Scenario 6: forced eq&&gt sets a sticky error
        force_err = 1'b1;
        launch(16'h0010, 16'h0020);
        step(S);
        chk("s6 err set", 32'(err), 32'd1);
        drain();
        force_err = 1'b0;
        step(4);
        launch(16'h0003, 16'h0003);
        step(S);
        chk("s6 clean res", 32'({res_eq, res_ae, res_gt, res_d}), 32'({3'b110, 4'd0}));
        chk("s6 err sticky", 32'(err), 32'd1);
        drain();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("s6 err cleared", 32'(err), 32'd0);

        // SETTLE_CYCLES=1 instance: capture every second edge, 4-bit count wraps at 16
        rst2 = 1'b0;
        step(1);
        chk("w out_valid e1", 32'(out_valid2), 32'd0);
        chk("w cmp_a e1", 32'(cmp_a2), 32'h0005);
        step(1);
        chk("w out_valid e2", 32'(out_valid2), 32'd1);
        chk("w txn e2", 32'(txn_count2), 32'd1);
        chk("w res e2", 32'({res_eq2, res_ae2, res_gt2, res_d2}), 32'({3'b001, 4'd2}));
        step(29);
        chk("w txn e31", 32'(txn_count2), 32'd15);
        chk("w out_valid e31", 32'(out_valid2), 32'd0);
        step(1);
        chk("w txn wrap", 32'(txn_count2), 32'd0);
        chk("w err", 32'(err2), 32'd0);

        chk_en = 1'b0;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
